// File: rtl/pipelined_adder.sv
// Pipelined chunked adder: STAGES register stages, stage k adds bits [k*CW +: CW].
// Define PIPELINED_ADDER_SUB_EN to enable the subtract mode driven by 'sub'.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int unsigned CW = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_eff      = b;
  assign cin_eff    = c_in;
`endif

  // Global stall: the whole pipe moves only when the output slot can be vacated.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned BW = WIDTH - k*CW;

    logic             v_in;
    logic             c_k;
    logic [WIDTH-1:0] x_in;
    logic [BW-1:0]    b_in;
    logic [CW:0]      chunk;
    logic [WIDTH-1:0] x_next;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] x_q;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign c_k  = cin_eff;
      assign x_in = a;
      assign b_in = b_eff;
    end else begin : g_link
      assign v_in = g_stage[k-1].v_q;
      assign c_k  = g_stage[k-1].c_q;
      assign x_in = g_stage[k-1].x_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
    end

    assign chunk = {1'b0, x_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + (CW+1)'(c_k);

    // x holds unconsumed 'a' chunks below finished sum chunks; rotating right by
    // one chunk per stage leaves the full sum in place after the last stage.
    if (STAGES == 1) begin : g_single
      assign x_next = chunk[CW-1:0];
    end else begin : g_rotate
      assign x_next = {chunk[CW-1:0], x_in[WIDTH-1:CW]};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        x_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= chunk[CW];
        x_q <= x_next;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [BW-CW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          b_q <= '0;
        end else if (advance) begin
          b_q <= b_in[BW-1:CW];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= x_in[CW-1] ^ b_in[CW-1] ^ chunk[CW-1] ^ chunk[CW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].x_q;
  assign c_out     = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Expected subtract-mode result follows PIPELINED_ADDER_SUB_EN.
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  logic [15:0] ta [10];
  logic [15:0] tb_op [10];
  logic        tc [10];
  logic [15:0] ts [10];
  logic        tco [10];
  logic        tov [10];

`ifdef PIPELINED_ADDER_SUB_EN
  localparam logic [15:0] SUB_SUM = 16'hFFFE;
`else
  localparam logic [15:0] SUB_SUM = 16'h000C;
`endif

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int recv;
    logic fire_in;
    logic fire_out;

    ta    = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h00FF, 16'h0FFF, 16'h1234, 16'hABCD, 16'hFFFF, 16'h4000};
    tb_op = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0001, 16'hEDCB, 16'h1111, 16'h0000, 16'h4000};
    tc    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ts    = '{16'h0002, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0100, 16'h1000, 16'h0000, 16'hBCDE, 16'h0000, 16'h8000};
    tco   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tov   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum",   sum,       0);
    chk("rst_cout",  c_out,     0);
    chk("rst_ovf",   ovf,       0);
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("idle_ready_no_out_ready", in_ready, 1);
    out_ready = 1'b1;

    // Wrap to zero with carry out, latency of STAGES-1 edges after acceptance
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("t1_lat0", out_valid, 0);
    tick; chk("t1_lat1", out_valid, 0);
    tick; chk("t1_lat2", out_valid, 0);
    tick;
    chk("t1_valid", out_valid, 1);
    chk("t1_sum",   sum,       16'h0000);
    chk("t1_cout",  c_out,     1);
    chk("t1_ovf",   ovf,       0);
    tick; chk("t1_drain", out_valid, 0);

    // Signed overflow, then a carry-in op one cycle behind
    a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
    tick;
    a = 16'h1234; b = 16'h4321; c_in = 1'b1;
    tick;
    in_valid = 1'b0; c_in = 1'b0;
    tick; tick;
    chk("t2a_valid", out_valid, 1);
    chk("t2a_sum",   sum,       16'h8000);
    chk("t2a_cout",  c_out,     0);
    chk("t2a_ovf",   ovf,       1);
    tick;
    chk("t2b_valid", out_valid, 1);
    chk("t2b_sum",   sum,       16'h5556);
    chk("t2b_cout",  c_out,     0);
    chk("t2b_ovf",   ovf,       0);
    tick; chk("t2_drain", out_valid, 0);

    // Ten back-to-back ops with downstream stalled in cycles 5-7
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        a = ta[sent]; b = tb_op[sent]; c_in = tc[sent];
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("burst_stall_ready", in_ready, 0);
        chk("burst_stall_sum",   sum,      ts[recv]);
        chk("burst_stall_cout",  c_out,    tco[recv]);
      end
      fire_out = out_valid && out_ready;
      fire_in  = in_valid && in_ready;
      if (fire_out) begin
        chk("burst_sum",  sum,   ts[recv]);
        chk("burst_cout", c_out, tco[recv]);
        chk("burst_ovf",  ovf,   tov[recv]);
        recv++;
      end
      if (fire_in) sent++;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1; c_in = 1'b0;
    chk("burst_sent",  sent,      10);
    chk("burst_recv",  recv,      10);
    chk("burst_nodup", out_valid, 0);

    // Reset with three ops in flight and a live op presented during reset
    a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    tick; tick; tick;
    reset = 1'b1; a = 16'hAAAA; b = 16'h5555;
    tick;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum",   sum,       0);
    chk("midrst_cout",  c_out,     0);
    chk("midrst_ovf",   ovf,       0);
    chk("midrst_ready", in_ready,  1);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("midrst_flushed", out_valid, 0);
    end
    a = 16'h0002; b = 16'h0003; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("post_lat0", out_valid, 0);
    tick; chk("post_lat1", out_valid, 0);
    tick; chk("post_lat2", out_valid, 0);
    tick;
    chk("post_valid", out_valid, 1);
    chk("post_sum",   sum,       16'h0005);

    // Subtract request
    a = 16'h0005; b = 16'h0007; c_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; sub = 1'b0;
    tick; tick; tick;
    chk("sub_valid", out_valid, 1);
    chk("sub_sum",   sum,       SUB_SUM);
    chk("sub_cout",  c_out,     0);
    chk("sub_ovf",   ovf,       0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be divisible by STAGES, giving chunk width CW = WIDTH/STAGES.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 c_in  input  1  carry-in.
REQ-009 sub  input  1  subtract request (see Configuration).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 c_out  output  1  carry-out of bit WIDTH-1.
REQ-014 ovf  output  1  two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

Function
REQ-015 A transfer in SHALL occur on a rising edge with in_valid && in_ready; a transfer out SHALL occur on a rising edge with out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k of a and b, bits [k*CW +: CW], with the carry registered from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-017 Unconsumed upper operand chunks SHALL be carried forward in skew registers, and completed lower sum chunks SHALL be carried forward in deskew registers, so each result is bit-exact to (a + b + c_in) mod 2^WIDTH.
REQ-018 Latency: for an operand accepted on edge E, with no stall, the result SHALL be on sum/c_out/ovf with out_valid=1 immediately after edge E+STAGES-1.
REQ-019 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-020 in_ready SHALL equal out_ready || !out_valid, combinationally.
REQ-021 When out_valid && !out_ready, all stages SHALL hold; sum, c_out and ovf SHALL stay stable; no result SHALL be lost or duplicated.
REQ-022 Empty stages (bubbles) SHALL advance normally during a stall if they are not blocked; a simpler global stall is acceptable provided REQ-019 through REQ-021 hold.
REQ-023 Each stage SHALL carry a valid bit; sum/c_out/ovf SHALL be don't-care when out_valid=0.
REQ-024 Simultaneous input and output transfers in the same cycle SHALL both complete.
REQ-025 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder with 1-cycle latency.

Reset
REQ-026 While reset=1 at a rising edge, all stage valid bits, out_valid, sum, c_out and ovf SHALL clear to 0.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight operation; in_ready SHALL be 1 in the first cycle after reset.
REQ-028 Inputs SHALL be ignored during any cycle in which reset=1.

Configuration
REQ-029 Macro PIPELINED_ADDER_SUB_EN defined: sub=1 SHALL compute a + ~b + 1, ignoring c_in, and c_out=1 SHALL mean no borrow; sub SHALL be captured with the operands.
REQ-030 Macro PIPELINED_ADDER_SUB_EN undefined: sub SHALL be ignored (treated as 0), and no inversion logic SHALL be synthesised.

Verification (WIDTH=16, STAGES=4)
REQ-031 a=0xFFFF, b=0x0001, c_in=0, out_ready=1, accepted on edge 0 -> out_valid after edge 3; sum=0x0000, c_out=1, ovf=0.
REQ-032 a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1; then a=0x1234, b=0x4321, c_in=1 issued the next cycle -> sum=0x5556 exactly one cycle later.
REQ-033 10 back-to-back operations with out_ready held low for cycles 5-7 -> in_ready low while out_valid && !out_ready; all 10 results arrive in order, none dropped or duplicated, outputs stable while stalled.
REQ-034 Reset pulsed with 3 operations in flight -> no out_valid afterward for those operations; the next operation 0x0002+0x0003 -> 0x0005 with 4-cycle latency.
REQ-035 With PIPELINED_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0; without it, same stimulus -> sum=0x000C, c_out=0.
